jacobian_transpose_step: RTL and testbench

//  Consumes the 6x6 Jacobian from the jacobian stage and the 6-element pose-error vector.

---
 rtl/jacobian_transpose_step.sv | 121 ++++++++++++
 tb/tb_jacobian_transpose_step.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/jacobian_transpose_step.sv
// rtl/jacobian_transpose_step.sv - dtheta = sat((J^T * e) >>> ALPHA_SHIFT) using one time-shared MAC
module jacobian_transpose_step #(
    parameter int DW          = 27,
    parameter int FRAC        = 16,
    parameter int ALPHA_SHIFT = 4,
    parameter int GUARD       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     start,
    input  logic [5:0][5:0][DW-1:0]  jacobian_matrix,
    input  logic [5:0][DW-1:0]       err,
    output logic                     busy,
    output logic                     done,
    output logic [5:0][DW-1:0]       dtheta
);

    localparam int AW = DW + GUARD;
    localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_SCALE,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [5:0][5:0][DW-1:0] jl;
    logic [5:0][DW-1:0]      el;
    logic [5:0][AW-1:0]      acc;
    logic [2:0]              row, col, col_d;
    logic [AW-1:0]           prod;
    logic                    prod_v;
    logic signed [2*DW-1:0]  mult;

    // Scale a final sum by alpha and clamp into the signed DW-bit output range.
    function automatic logic [DW-1:0] scale_sat(input logic [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = $signed(a) >>> ALPHA_SHIFT;
        if (s > SAT_MAX)      s = SAT_MAX;
        else if (s < SAT_MIN) s = SAT_MIN;
        return DW'(s);
    endfunction

    assign mult = $signed(jl[row][col]) * $signed(el[row]);
    assign busy = (state == S_MAC) || (state == S_DRAIN) || (state == S_SCALE);
    assign done = (state == S_DONE);

    // Next-state logic; the en gate lives in the state register.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_MAC;
            S_MAC:   if (row == 3'd5 && col == 3'd5) state_n = S_DRAIN;
            S_DRAIN: state_n = S_SCALE;
            S_SCALE: state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register; a stalled cycle leaves the FSM where it is.
    always_ff @(posedge clk) begin
        if (reset)   state <= S_IDLE;
        else if (en) state <= state_n;
    end

    // Datapath: operand capture, pipelined multiply/accumulate and final scaling.
    always_ff @(posedge clk) begin
        if (reset) begin
            jl     <= '0;
            el     <= '0;
            acc    <= '0;
            row    <= '0;
            col    <= '0;
            col_d  <= '0;
            prod   <= '0;
            prod_v <= 1'b0;
            dtheta <= '0;
        end else if (en) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        jl     <= jacobian_matrix;
                        el     <= err;
                        acc    <= '0;
                        row    <= '0;
                        col    <= '0;
                        prod_v <= 1'b0;
                    end
                end
                S_MAC: begin
                    prod   <= AW'(mult >>> FRAC);
                    prod_v <= 1'b1;
                    col_d  <= col;
                    if (prod_v) acc[col_d] <= acc[col_d] + prod;
                    if (row == 3'd5) begin
                        row <= '0;
                        col <= col + 3'd1;
                    end else begin
                        row <= row + 3'd1;
                    end
                end
                S_DRAIN: begin
                    if (prod_v) acc[col_d] <= acc[col_d] + prod;
                    prod_v <= 1'b0;
                end
                S_SCALE: begin
                    for (int c = 0; c < 6; c++) dtheta[c] <= scale_sat(acc[c]);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jacobian_transpose_step.sv
// tb/tb_jacobian_transpose_step.sv - table-driven scoreboard bench for jacobian_transpose_step
module tb_jacobian_transpose_step;

    typedef logic [5:0][26:0]       vecd_t;
    typedef logic [5:0][5:0][26:0]  mat_t;
    typedef struct {
        mat_t  j;
        vecd_t e;
        vecd_t exp;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset, en, start;
    mat_t  jm;
    vecd_t er;
    logic  busy, done;
    vecd_t dtheta;

    int    n_vec = 0;
    int    n_bad = 0;
    vecd_t exp_q[$];
    vec_t  tbl[8];

    jacobian_transpose_step dut (
        .clk(clk), .reset(reset), .en(en), .start(start),
        .jacobian_matrix(jm), .err(er),
        .busy(busy), .done(done), .dtheta(dtheta)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic longint sx(input logic [26:0] v);
        return longint'($signed(v));
    endfunction

    function automatic vecd_t model(input mat_t j, input vecd_t e);
        vecd_t  r;
        longint s;
        for (int c = 0; c < 6; c++) begin
            s = 0;
            for (int k = 0; k < 6; k++) s += (sx(j[k][c]) * sx(e[k])) >>> 16;
            s = s >>> 4;
            if (s > 64'sd67108863)  s = 64'sd67108863;
            if (s < -64'sd67108864) s = -64'sd67108864;
            r[c] = 27'(s);
        end
        return r;
    endfunction

    task automatic cmp_out(input string nm, input vecd_t want);
        for (int c = 0; c < 6; c++) check($sformatf("%s.dtheta[%0d]", nm, c), sx(dtheta[c]), sx(want[c]));
    endtask

    // Issue a request; returns at the sample just after the accepting edge.
    task automatic start_job(input mat_t j, input vecd_t e, input vecd_t exp);
        jm = j;
        er = e;
        start = 1'b1;
        exp_q.push_back(exp);
        tick();
        start = 1'b0;
    endtask

    // Wait for done (bounded), optionally stalling or re-pulsing start, then score the result.
    task automatic run_wait(input string nm, input int stall_at, input int stall_n,
                            input int restart_at, input mat_t alt,
                            output int lat, output int busy_n);
        vecd_t want;
        int    idx;
        idx = 1;
        busy_n = 0;
        while (!done && idx < 300) begin
            if (busy) busy_n++;
            if (idx == stall_at) en = 1'b0;
            if (idx == stall_at + stall_n) en = 1'b1;
            if (idx == restart_at) begin
                start = 1'b1;
                jm = alt;
            end else begin
                start = 1'b0;
            end
            tick();
            idx++;
        end
        en = 1'b1;
        start = 1'b0;
        lat = idx;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (!done) check({nm, ".timeout"}, 0, 1);
        else cmp_out(nm, want);
    endtask

    initial begin
        int   lat, bn;
        mat_t zm;
        zm = '0;

        // Table: identity, all ones, near-full-scale of each sign, random.
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) begin
                tbl[0].j[r][c] = (r == c) ? 27'd65536 : 27'd0;
                tbl[1].j[r][c] = 27'd65536;
                tbl[2].j[r][c] = 27'h3FFFFFF;
                tbl[3].j[r][c] = 27'h4000000;
                tbl[4].j[r][c] = 27'h4000000;
            end
        tbl[0].e   = {27'(-16384), 27'd0, 27'd32768, 27'(-65536), 27'd131072, 27'd65536};
        tbl[0].exp = {27'(-1024), 27'd0, 27'd2048, 27'(-4096), 27'd8192, 27'd4096};
        for (int r = 0; r < 6; r++) begin
            tbl[1].e[r]   = 27'd65536;
            tbl[1].exp[r] = 27'd24576;
            tbl[2].e[r]   = 27'd174762;
            tbl[3].e[r]   = 27'd174762;
            tbl[4].e[r]   = 27'(-174762);
        end
        for (int v = 5; v < 8; v++) begin
            for (int r = 0; r < 6; r++) begin
                tbl[v].e[r] = 27'(int'($urandom_range(2097152, 0)) - 1048576);
                for (int c = 0; c < 6; c++)
                    tbl[v].j[r][c] = 27'(int'($urandom_range(2097152, 0)) - 1048576);
            end
        end
        for (int v = 2; v < 8; v++) tbl[v].exp = model(tbl[v].j, tbl[v].e);

        // Reset state.
        reset = 1'b1; en = 1'b1; start = 1'b0; jm = '0; er = '0;
        repeat (3) tick();
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        cmp_out("reset", '0);
        reset = 1'b0;
        tick();

        // Table sweep with latency and busy-length checks.
        for (int v = 0; v < 8; v++) begin
            start_job(tbl[v].j, tbl[v].e, tbl[v].exp);
            run_wait($sformatf("vec%0d", v), -1, 0, -1, zm, lat, bn);
            check($sformatf("vec%0d.latency", v), lat, 39);
            check($sformatf("vec%0d.busy_cycles", v), bn, 38);
            tick();
            check($sformatf("vec%0d.done_pulse", v), done, 0);
        end

        // Start re-pulsed with a different J while busy: ignored, inputs changed after capture.
        start_job(tbl[5].j, tbl[5].e, tbl[5].exp);
        run_wait("restart", -1, 0, 10, tbl[1].j, lat, bn);
        check("restart.latency", lat, 39);
        // Back-to-back: start held through the done cycle is taken once IDLE.
        jm = tbl[6].j; er = tbl[6].e; start = 1'b1;
        exp_q.push_back(tbl[6].exp);
        tick();
        check("b2b.done_cycle_ignored", busy, 0);
        tick();
        start = 1'b0;
        check("b2b.accepted", busy, 1);
        run_wait("b2b", -1, 0, -1, zm, lat, bn);
        check("b2b.latency", lat, 39);
        tick();

        // Stall for five cycles mid-computation.
        start_job(tbl[7].j, tbl[7].e, tbl[7].exp);
        run_wait("stall", 5, 5, -1, zm, lat, bn);
        check("stall.latency", lat, 44);
        check("stall.busy_cycles", bn, 43);
        // en low during DONE stretches done.
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stretch.done%0d", k), done, 1);
        end
        en = 1'b1;
        tick();
        check("stretch.done_drop", done, 0);
        check("stretch.busy", busy, 0);

        // Reset mid-operation.
        start_job(tbl[2].j, tbl[2].e, tbl[2].exp);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        void'(exp_q.pop_back());
        check("midreset.busy", busy, 0);
        check("midreset.done", done, 0);
        cmp_out("midreset", '0);
        // Reset and start together: start is lost.
        jm = tbl[1].j; er = tbl[1].e; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        tick();
        check("reset_start.busy", busy, 0);
        // Normal completion afterwards.
        start_job(tbl[0].j, tbl[0].e, tbl[0].exp);
        run_wait("post_reset", -1, 0, -1, zm, lat, bn);
        check("post_reset.latency", lat, 39);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
